// File: rtl/a5_1_keystream.sv
//----------------------------------------------------------------------------
// a5_1_keystream - A5/1 keystream core, 228 bits as 8 words over valid/ready
// Rev 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module a5_1_keystream #(
  parameter int MIX_CYCLES = 100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [63:0] key_i,
  input  logic [21:0] frame_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        ks_valid_o,
  input  logic        ks_ready_i,
  output logic [31:0] ks_dat_o,
  output logic        ks_dir_o,
  output logic        ks_last_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_FRAME = 3'd2,
    S_MIX   = 3'd3,
    S_GEN   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  localparam logic [18:0] c_R1_TAPS  = 19'h72000;
  localparam logic [21:0] c_R2_TAPS  = 22'h300000;
  localparam logic [22:0] c_R3_TAPS  = 23'h700080;
  localparam logic [7:0]  c_MIX_LAST = 8'(MIX_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt,   w_cnt_nxt;
  logic [2:0]  r_word,  w_word_nxt;
  logic [18:0] r_r1,    w_r1_nxt;
  logic [21:0] r_r2,    w_r2_nxt;
  logic [22:0] r_r3,    w_r3_nxt;
  logic [31:0] r_shift, w_shift_nxt;

  logic        w_inbit, w_load, w_maj, w_ob, w_word_done;
  logic        w_en1, w_en2, w_en3;
  logic [18:0] w_r1_adv;
  logic [21:0] w_r2_adv;
  logic [22:0] w_r3_adv;
  logic [4:0]  w_bitpos;

  assign w_load  = (r_state == S_KEY) || (r_state == S_FRAME);
  assign w_inbit = (r_state == S_KEY)   ? key_i[r_cnt[5:0]]   :
                   (r_state == S_FRAME) ? frame_i[r_cnt[4:0]] : 1'b0;

  assign w_maj = (r_r1[8] & r_r2[10]) | (r_r1[8] & r_r3[10]) | (r_r2[10] & r_r3[10]);
  assign w_en1 = w_load | (r_r1[8]  == w_maj);
  assign w_en2 = w_load | (r_r2[10] == w_maj);
  assign w_en3 = w_load | (r_r3[10] == w_maj);

  assign w_r1_adv = w_en1 ? {r_r1[17:0], (^(r_r1 & c_R1_TAPS)) ^ w_inbit} : r_r1;
  assign w_r2_adv = w_en2 ? {r_r2[20:0], (^(r_r2 & c_R2_TAPS)) ^ w_inbit} : r_r2;
  assign w_r3_adv = w_en3 ? {r_r3[21:0], (^(r_r3 & c_R3_TAPS)) ^ w_inbit} : r_r3;

  // Keystream bit is taken from the post-step register contents
  assign w_ob        = w_r1_adv[18] ^ w_r2_adv[21] ^ w_r3_adv[22];
  assign w_bitpos    = 5'd31 - r_cnt[4:0];
  assign w_word_done = (r_word[1:0] == 2'd3) ? (r_cnt == 8'd17) : (r_cnt == 8'd31);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_r1_nxt    = r_r1;
    w_r2_nxt    = r_r2;
    w_r3_nxt    = r_r3;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_KEY;
          w_cnt_nxt   = '0;
          w_word_nxt  = '0;
          w_r1_nxt    = '0;
          w_r2_nxt    = '0;
          w_r3_nxt    = '0;
          w_shift_nxt = '0;
        end
      end
      S_KEY, S_FRAME, S_MIX: begin
        w_r1_nxt = w_r1_adv;
        w_r2_nxt = w_r2_adv;
        w_r3_nxt = w_r3_adv;
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_state == S_KEY && r_cnt == 8'd63) begin
          w_state_nxt = S_FRAME;
          w_cnt_nxt   = '0;
        end else if (r_state == S_FRAME && r_cnt == 8'd21) begin
          w_state_nxt = S_MIX;
          w_cnt_nxt   = '0;
        end else if (r_state == S_MIX && r_cnt == c_MIX_LAST) begin
          w_state_nxt = S_GEN;
          w_cnt_nxt   = '0;
        end
      end
      S_GEN: begin
        w_r1_nxt = w_r1_adv;
        w_r2_nxt = w_r2_adv;
        w_r3_nxt = w_r3_adv;
        if (r_cnt == 8'd0) begin
          w_shift_nxt = '0;
        end
        w_shift_nxt[w_bitpos] = w_ob;
        if (w_word_done) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (ks_ready_i) begin
          if (r_word == 3'd7) begin
            w_state_nxt = S_IDLE;
            w_word_nxt  = '0;
          end else begin
            w_state_nxt = S_GEN;
            w_word_nxt  = r_word + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a coincident start in IDLE
    if (abort_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_word_nxt  = '0;
      w_shift_nxt = '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_r1    <= w_r1_nxt;
      r_r2    <= w_r2_nxt;
      r_r3    <= w_r3_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign ks_valid_o = (r_state == S_HOLD);
  assign ks_dat_o   = r_shift;
  assign ks_dir_o   = r_word[2];
  assign ks_last_o  = ks_valid_o & (r_word == 3'd7);

endmodule

`default_nettype wire

// File: tb/tb_a5_1_keystream.sv
//----------------------------------------------------------------------------
// tb_a5_1_keystream - scoreboard bench for the A5/1 keystream core
// Rev 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_a5_1_keystream;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [63:0] key   = '0;
  logic [21:0] frame = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic        busy, valid, dir, last;
  logic [31:0] dat;

  always #5 clk = ~clk;

  a5_1_keystream #(.MIX_CYCLES(100)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .key_i      (key),
    .frame_i    (frame),
    .start_i    (start),
    .abort_i    (abort),
    .busy_o     (busy),
    .ks_valid_o (valid),
    .ks_ready_i (ready),
    .ks_dat_o   (dat),
    .ks_dir_o   (dir),
    .ks_last_o  (last)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        dir;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t held_v;
  bit   held      = 1'b0;
  int   n_chk     = 0;
  int   n_fail    = 0;
  int   acc_cnt   = 0;
  int   scen_base = 0;
  int   rdy_mode  = 0;
  int   stall     = 0;

  localparam logic [63:0] c_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] c_FRAME = 22'h134;
  logic [31:0] ref_words [8] = '{32'h534EAA58, 32'h2FE8151A, 32'hB6E1855A, 32'h728C0000,
                                 32'h24FD35A3, 32'h5D5FB652, 32'h6D32F906, 32'hDF1AC000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer LFSRs driven straight from the A5/1 rules
  function automatic int unsigned lfsr_step(int unsigned r, int unsigned mask,
                                            int unsigned taps, bit inb);
    return ((r << 1) & mask) | (32'($countones(r & taps) & 1) ^ 32'(inb));
  endfunction

  task automatic a5_ref(input logic [63:0] k, input logic [21:0] f, output logic [227:0] s);
    int unsigned r1 = 0, r2 = 0, r3 = 0;
    int unsigned c1, c2, c3, maj;
    s = '0;
    for (int i = 0; i < 86; i++) begin
      bit b;
      b  = (i < 64) ? k[i] : f[i-64];
      r1 = lfsr_step(r1, 32'h7FFFF,  32'h72000,  b);
      r2 = lfsr_step(r2, 32'h3FFFFF, 32'h300000, b);
      r3 = lfsr_step(r3, 32'h7FFFFF, 32'h700080, b);
    end
    for (int i = 0; i < 100 + 228; i++) begin
      c1  = (r1 >> 8) & 1;
      c2  = (r2 >> 10) & 1;
      c3  = (r3 >> 10) & 1;
      maj = ((c1 + c2 + c3) >= 2) ? 1 : 0;
      if (c1 == maj) r1 = lfsr_step(r1, 32'h7FFFF,  32'h72000,  1'b0);
      if (c2 == maj) r2 = lfsr_step(r2, 32'h3FFFFF, 32'h300000, 1'b0);
      if (c3 == maj) r3 = lfsr_step(r3, 32'h7FFFFF, 32'h700080, 1'b0);
      if (i >= 100) s[i-100] = 1'(((r1 >> 18) ^ (r2 >> 21) ^ (r3 >> 22)) & 1);
    end
  endtask

  task automatic push_stream(input logic [227:0] s);
    int p = 0;
    for (int w = 0; w < 8; w++) begin
      int len;
      logic [31:0] wd;
      len = (w % 4 == 3) ? 18 : 32;
      wd  = '0;
      for (int k = 0; k < len; k++) wd[31-k] = s[p+k];
      p += len;
      exp_q.push_back('{dat: wd, dir: (w >= 4), last: (w == 7)});
    end
  endtask

  task automatic push_ref(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{dat: ref_words[i], dir: (i >= 4), last: (i == 7)});
  endtask

  task automatic start_run(input logic [63:0] k, input logic [21:0] f);
    scen_base = acc_cnt;
    key   = k;
    frame = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 6000) begin
      tick();
      t++;
    end
    check("idle_reached", 64'(busy), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted word, checks HOLD stability
  initial forever begin
    @(negedge clk);
    if (valid) begin
      if (held) check("hold_stable", 64'({dat, dir, last}), 64'(held_v));
      if (ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: actual %0h required none", dat);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", 64'(dat), 64'(mon_e.dat));
          check("word_dir",  64'(dir), 64'(mon_e.dir));
          check("word_last", 64'(last), 64'(mon_e.last));
        end
        acc_cnt++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_v = '{dat: dat, dir: dir, last: last};
      end
    end else begin
      held = 1'b0;
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = 50-cycle stall on word 1 then random
  initial forever begin
    @(posedge clk);
    #1;
    if (acc_cnt == scen_base) stall = 0;
    case (rdy_mode)
      0: ready = 1'b1;
      1: ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (valid && (acc_cnt - scen_base) == 1 && stall < 50) begin
          ready = 1'b0;
          stall++;
        end else begin
          ready = ($urandom_range(0, 2) != 0);
        end
      end
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [227:0] s;
    int lat;
    int t;
    bit busy_ok;

    #2 rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_dat", 64'(dat), 64'd0);
    check("rst_dir", 64'(dir), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reference vector, always ready, with latency measurement
    rdy_mode = 0;
    push_ref(8);
    start_run(c_KEY, c_FRAME);
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    busy_ok = 1'b1;
    while (!valid && lat < 400) begin
      tick();
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    check("first_word_latency", 64'(lat), 64'd218);
    check("busy_held_to_first_word", 64'(busy_ok), 64'd1);
    wait_idle();

    // Backpressure: long stall on word 1, random afterwards
    rdy_mode = 2;
    push_ref(8);
    start_run(c_KEY, c_FRAME);
    wait_idle();
    check("bp_stall_cycles", 64'(stall), 64'd50);

    // start pulses during MIX and during HOLD are ignored
    rdy_mode = 0;
    push_ref(8);
    start_run(c_KEY, c_FRAME);
    repeat (149) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!valid && t < 400) begin
      tick();
      t++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    // Abort during generation of word 2
    push_ref(2);
    start_run(c_KEY, c_FRAME);
    t = 0;
    while ((acc_cnt - scen_base) < 2 && t < 3000) begin
      tick();
      t++;
    end
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);

    // Simultaneous start and abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);

    push_ref(8);
    start_run(c_KEY, c_FRAME);
    wait_idle();

    // Asynchronous reset in the middle of key load
    start_run(c_KEY, c_FRAME);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_dat", 64'(dat), 64'd0);
    check("midrst_last", 64'(last), 64'd0);
    repeat (2) tick();
    #2 rst = 1'b0;
    repeat (300) tick();
    check("post_rst_idle", 64'(busy), 64'd0);
    push_ref(8);
    start_run(c_KEY, c_FRAME);
    wait_idle();

    // Random keys and frames against the reference model
    rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      logic [63:0] rk;
      logic [21:0] rf;
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      a5_ref(rk, rf, s);
      push_stream(s);
      start_run(rk, rf);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
